// File: rtl/falu_result_stage.sv
// falu_result_stage: registered output stage behind the binary32 FP ALU.
// It classifies each accepted result, holds it in a two-entry FIFO and
// keeps sticky class flags plus a saturating count of delivered results.
// in_ready depends only on local registers, so backpressure from the
// consumer never reaches back into the ALU combinationally.
module falu_result_stage #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [1:0]       out_op,
  output logic [2:0]       out_class,
  output logic             out_sign,
  output logic [3:0]       sticky,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    CLS_NORMAL = 3'b000,
    CLS_ZERO   = 3'b001,
    CLS_SUB    = 3'b010,
    CLS_INF    = 3'b011,
    CLS_NAN    = 3'b100
  } cls_e;

  logic [7:0]  in_exp;
  logic [22:0] in_mant;
  cls_e        in_class;
  logic [3:0]  push_flags;

  logic [N-1:0] data_q  [2];
  logic [1:0]   op_q    [2];
  logic [2:0]   class_q [2];
  logic         head;
  logic         tail;
  logic [1:0]   occ;

  logic push;
  logic pop;

  assign in_exp  = in_data[30:23];
  assign in_mant = in_data[22:0];

  // Classify the incoming result from its exponent and mantissa fields.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    in_class = CLS_NORMAL;
    if (in_exp == 8'hFF) begin
      in_class = (in_mant != '0) ? CLS_NAN : CLS_INF;
    end else if (in_exp == 8'h00) begin
      in_class = (in_mant == '0) ? CLS_ZERO : CLS_SUB;
    end
  end

  // Map the class to its sticky bit {nan, inf, sub, zero}; normal sets none.
  always_comb begin
    push_flags = 4'b0000;
    case (in_class)
      CLS_NAN:  push_flags = 4'b1000;
      CLS_INF:  push_flags = 4'b0100;
      CLS_SUB:  push_flags = 4'b0010;
      CLS_ZERO: push_flags = 4'b0001;
      default:  push_flags = 4'b0000;
    endcase
  end

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointers and occupancy; a simultaneous push and pop leaves occupancy alone.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Entry storage written at the tail on every push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; occupancy alone decides which entries are meaningful.
    if (push) begin
      data_q[tail]  <= in_data;
      op_q[tail]    <= in_op;
      class_q[tail] <= in_class;
    end
  end

  // Sticky class flags; clear wins over history but keeps a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= 4'b0000;
    end else if (clr) begin
      sticky <= push ? push_flags : 4'b0000;
    end else if (push) begin
      sticky <= sticky | push_flags;
    end
  end

  // Saturating delivered-result counter; a pop during clear counts as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= pop ? CNT_W'(1) : '0;
    end else if (pop && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

  assign out_data  = data_q[head];
  assign out_op    = op_q[head];
  assign out_class = class_q[head];
  assign out_sign  = out_data[N-1];

endmodule
